// File: rtl/uart_rx_word.sv
// uart_rx_word: assembles WORD_BYTES received UART bytes (MSB first, closed by TERM)
// into one word. It checks framing, enforces an inter-byte gap timeout and holds a
// one-deep output buffer with a valid/ready handshake.
module uart_rx_word #(
  parameter int unsigned WORD_BYTES  = 4,
  parameter logic [7:0]  TERM        = 8'h0D,
  parameter int unsigned GAP_TIMEOUT = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  output logic [8*WORD_BYTES-1:0] o_word,
  output logic                    o_word_valid,
  input  logic                    i_word_ready,
  output logic                    o_frame_err,
  output logic                    o_overrun
);

  localparam int unsigned W        = 8 * WORD_BYTES;
  localparam int unsigned CW       = $clog2(WORD_BYTES + 1);
  localparam int unsigned GW       = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT) : 1;
  // The counter expires on the cycle that would have taken it to GAP_TIMEOUT, so it
  // never needs to hold GAP_TIMEOUT itself.
  localparam int unsigned GAP_LAST = (GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE,  // no bytes of a frame held
    ST_DATA,  // 1..WORD_BYTES-1 data bytes held
    ST_TERM,  // all data bytes held, terminator expected next
    ST_HUNT   // after a framing error, dropping bytes until a terminator
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gap;
  logic [W-1:0]  shreg;

  logic in_frame;
  logic gap_expired;
  logic complete;
  logic handshake;

  assign in_frame    = (state == ST_DATA) || (state == ST_TERM);
  // A strobe in the expiry cycle takes priority, so expiry requires a quiet input.
  assign gap_expired = (GAP_TIMEOUT != 0) && in_frame && !i_rx_valid &&
                       (gap == GW'(GAP_LAST));
  assign complete    = i_rx_valid && (state == ST_TERM) && (i_rx_data == TERM);
  assign handshake   = o_word_valid && i_word_ready;

  // Frame FSM, gap timer, output buffer and registered error/overrun pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      gap          <= '0;
      shreg        <= '0;
      o_word       <= '0;
      o_word_valid <= 1'b0;
      o_frame_err  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below reads the
      // pre-edge values of state, cnt, gap and o_word_valid.
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;

      // The gap timer runs only while a frame is partially received and restarts on
      // every byte.
      if (in_frame && !i_rx_valid && (GAP_TIMEOUT != 0) && !gap_expired) begin
        gap <= gap + 1'b1;
      end else begin
        gap <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            // Data bytes equal to TERM are legal here, because only the byte after
            // the last data byte is checked against TERM.
            shreg <= (shreg << 8) | W'(i_rx_data);
            cnt   <= CW'(1);
            state <= (WORD_BYTES == 1) ? ST_TERM : ST_DATA;
          end
        end

        ST_DATA: begin
          if (i_rx_valid) begin
            shreg <= (shreg << 8) | W'(i_rx_data);
            cnt   <= cnt + 1'b1;
            if ((cnt + 1'b1) == CW'(WORD_BYTES)) begin
              state <= ST_TERM;
            end
          end else if (gap_expired) begin
            o_frame_err <= 1'b1;
            cnt         <= '0;
            state       <= ST_IDLE;
          end
        end

        ST_TERM: begin
          if (i_rx_valid) begin
            cnt <= '0;
            if (i_rx_data == TERM) begin
              state <= ST_IDLE;
            end else begin
              o_frame_err <= 1'b1;
              state       <= ST_HUNT;
            end
          end else if (gap_expired) begin
            o_frame_err <= 1'b1;
            cnt         <= '0;
            state       <= ST_IDLE;
          end
        end

        ST_HUNT: begin
          if (i_rx_valid && (i_rx_data == TERM)) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase

      // One-deep buffer. A completion that coincides with the consumer taking the
      // held word reloads it. Otherwise a completion while full is dropped.
      if (complete) begin
        if (!o_word_valid || i_word_ready) begin
          o_word       <= shreg;
          o_word_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (handshake) begin
        o_word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed scenarios followed by randomized byte streams. Each cycle
// is compared against a frame-level reference model that tracks the partial frame
// as a byte queue.
module tb_uart_rx_word;

  localparam int         GAP  = 16;
  localparam logic [7:0] TERM = 8'h0D;

  logic        clk;
  logic        rst;
  logic [7:0]  i_rx_data;
  logic        i_rx_valid;
  logic [31:0] o_word;
  logic        o_word_valid;
  logic        i_word_ready;
  logic        o_frame_err;
  logic        o_overrun;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [7:0]  frame_q[$];
  bit          hunting;
  int          idle_n;
  bit          m_valid;
  logic [31:0] m_word;
  bit          e_err;
  bit          e_ovr;

  uart_rx_word #(
    .WORD_BYTES (4),
    .TERM       (TERM),
    .GAP_TIMEOUT(GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_rx_data   (i_rx_data),
    .i_rx_valid  (i_rx_valid),
    .o_word      (o_word),
    .o_word_valid(o_word_valid),
    .i_word_ready(i_word_ready),
    .o_frame_err (o_frame_err),
    .o_overrun   (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    hunting = 1'b0;
    idle_n  = 0;
    m_valid = 1'b0;
    m_word  = '0;
    e_err   = 1'b0;
    e_ovr   = 1'b0;
  endtask

  // Predicts the outputs after the coming edge from the inputs applied in this cycle.
  task automatic model_step(input bit v, input logic [7:0] b, input bit r);
    bit          hs;
    bit          done;
    logic [31:0] w;
    hs    = m_valid && r;
    done  = 1'b0;
    w     = '0;
    e_err = 1'b0;
    e_ovr = 1'b0;
    if (v) begin
      idle_n = 0;
      if (hunting) begin
        if (b == TERM) hunting = 1'b0;
      end else if (frame_q.size() == 4) begin
        if (b == TERM) begin
          foreach (frame_q[i]) w = w * 256 + 32'(frame_q[i]);
          done = 1'b1;
        end else begin
          e_err   = 1'b1;
          hunting = 1'b1;
        end
        frame_q.delete();
      end else begin
        frame_q.push_back(b);
      end
    end else if (!hunting && frame_q.size() > 0) begin
      idle_n++;
      if (idle_n == GAP) begin
        e_err  = 1'b1;
        idle_n = 0;
        frame_q.delete();
      end
    end
    if (done) begin
      if (!m_valid || hs) begin
        m_word  = w;
        m_valid = 1'b1;
      end else begin
        e_ovr = 1'b1;
      end
    end else if (hs) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock cycle: apply inputs, advance the model, then compare just after the edge.
  task automatic tick(input bit v, input logic [7:0] b, input bit r);
    i_rx_valid   = v;
    i_rx_data    = b;
    i_word_ready = r;
    model_step(v, b, r);
    @(posedge clk);
    #1;
    check("word", o_word, m_word);
    check("word_valid", 32'(o_word_valid), 32'(m_valid));
    check("frame_err", 32'(o_frame_err), 32'(e_err));
    check("overrun", 32'(o_overrun), 32'(e_ovr));
    i_rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input bit r, input int gap_max);
    for (int i = 3; i >= 0; i--) begin
      tick(1'b1, w[8*i +: 8], r);
      repeat ($urandom_range(0, gap_max)) tick(1'b0, 8'h00, r);
    end
    tick(1'b1, TERM, r);
  endtask

  initial begin
    int          err_at;
    logic [7:0]  b;
    bit          r;
    int          kind;

    rst          = 1'b1;
    i_rx_data    = 8'h00;
    i_rx_valid   = 1'b0;
    i_word_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_word", o_word, 32'h0);
    check("rst_valid", 32'(o_word_valid), 32'h0);
    check("rst_err", 32'(o_frame_err), 32'h0);
    check("rst_ovr", 32'(o_overrun), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // 1: basic frame, word valid one edge after the terminator
    send_frame(32'h12345678, 1'b1, 0);
    check("t1_word", o_word, 32'h12345678);
    check("t1_valid", 32'(o_word_valid), 32'h1);
    tick(1'b0, 8'h00, 1'b1);

    // 2: terminator value used as data
    tick(1'b1, 8'hDE, 1'b1);
    tick(1'b1, 8'hAD, 1'b1);
    tick(1'b1, 8'h0D, 1'b1);
    tick(1'b1, 8'hBE, 1'b1);
    tick(1'b1, TERM, 1'b1);
    check("t2_word", o_word, 32'hDEAD0DBE);
    tick(1'b0, 8'h00, 1'b1);

    // 3: bad terminator, hunt, then a good frame
    tick(1'b1, 8'h11, 1'b1);
    tick(1'b1, 8'h22, 1'b1);
    tick(1'b1, 8'h33, 1'b1);
    tick(1'b1, 8'h44, 1'b1);
    tick(1'b1, 8'h55, 1'b1);
    check("t3_err", 32'(o_frame_err), 32'h1);
    tick(1'b1, 8'hAA, 1'b1);
    tick(1'b1, 8'hBB, 1'b1);
    tick(1'b1, 8'hCC, 1'b1);
    tick(1'b1, 8'hDD, 1'b1);
    tick(1'b1, TERM, 1'b1);
    check("t3_no_word", 32'(o_word_valid), 32'h0);
    send_frame(32'h01020304, 1'b1, 0);
    check("t3_word", o_word, 32'h01020304);
    tick(1'b0, 8'h00, 1'b1);

    // 4: gap timeout fires on the 16th idle cycle, then recovery
    tick(1'b1, 8'h01, 1'b1);
    tick(1'b1, 8'h02, 1'b1);
    err_at = 0;
    for (int i = 1; i <= 20; i++) begin
      tick(1'b0, 8'h00, 1'b1);
      if (o_frame_err === 1'b1 && err_at == 0) err_at = i;
    end
    check("t4_err_cycle", 32'(err_at), 32'd16);
    send_frame(32'hA1A2A3A4, 1'b1, 0);
    check("t4_word", o_word, 32'hA1A2A3A4);
    // A strobe arriving in the expiry cycle is accepted and raises no error.
    tick(1'b1, 8'hB1, 1'b1);
    repeat (GAP - 1) tick(1'b0, 8'h00, 1'b1);
    tick(1'b1, 8'hB2, 1'b1);
    check("t4_edge_no_err", 32'(o_frame_err), 32'h0);
    tick(1'b1, 8'hB3, 1'b1);
    tick(1'b1, 8'hB4, 1'b1);
    tick(1'b1, TERM, 1'b1);
    check("t4_edge_word", o_word, 32'hB1B2B3B4);
    tick(1'b0, 8'h00, 1'b1);

    // 5: overrun while the buffer is full, then a completion on the handshake cycle
    send_frame(32'h00000001, 1'b0, 0);
    send_frame(32'h00000002, 1'b0, 0);
    check("t5_ovr", 32'(o_overrun), 32'h1);
    check("t5_held", o_word, 32'h00000001);
    tick(1'b0, 8'h00, 1'b0);
    check("t5_ovr_pulse", 32'(o_overrun), 32'h0);
    tick(1'b0, 8'h00, 1'b1);
    send_frame(32'h00000001, 1'b0, 0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h00, 1'b0);
    tick(1'b1, 8'h02, 1'b0);
    tick(1'b1, TERM, 1'b1);
    check("t5_swap_word", o_word, 32'h00000002);
    check("t5_swap_valid", 32'(o_word_valid), 32'h1);
    check("t5_swap_ovr", 32'(o_overrun), 32'h0);
    tick(1'b0, 8'h00, 1'b1);

    // 6: asynchronous reset mid-frame with a word held
    send_frame(32'h55667788, 1'b0, 0);
    tick(1'b1, 8'hAB, 1'b0);
    tick(1'b1, 8'hCD, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_rst_word", o_word, 32'h0);
    check("t6_rst_valid", 32'(o_word_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(32'h0F0E0D0C, 1'b1, 0);
    check("t6_word", o_word, 32'h0F0E0D0C);
    tick(1'b0, 8'h00, 1'b1);

    // Randomized traffic: good frames, bad terminators, timeouts and raw streams
    for (int n = 0; n < 80; n++) begin
      kind = int'($urandom_range(0, 3));
      r    = 1'($urandom_range(0, 1));
      case (kind)
        0: send_frame($urandom, r, 3);
        1: begin
          repeat (4) tick(1'b1, 8'($urandom), r);
          b = 8'($urandom);
          if (b == TERM) b = 8'h00;
          tick(1'b1, b, r);
          repeat ($urandom_range(0, 3)) tick(1'b1, 8'($urandom), r);
          tick(1'b1, TERM, r);
        end
        2: begin
          repeat ($urandom_range(1, 4)) tick(1'b1, 8'($urandom), r);
          repeat ($urandom_range(12, 20)) tick(1'b0, 8'h00, r);
        end
        default: begin
          for (int k = 0; k < 30; k++) begin
            b = ($urandom_range(0, 3) == 0) ? TERM : 8'($urandom);
            tick(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 1)));
          end
        end
      endcase
      repeat ($urandom_range(0, 2)) tick(1'b0, 8'h00, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
